// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: load size and sequencer state encodings plus the field mask helper
package load_align_unit_pkg;
  typedef enum logic [1:0] {LS_BYTE, LS_HALF, LS_WORD, LS_DWORD} ls_size_e;
  typedef enum logic [1:0] {LAU_IDLE, LAU_RD0, LAU_RD1, LAU_RESP} lau_state_e;
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    return size == LS_BYTE ? 64'hFF :
           size == LS_HALF ? 64'hFFFF :
           size == LS_WORD ? 64'hFFFF_FFFF : '1;
  endfunction
endpackage

// File: rtl/load_format.sv
// load_format: shifts {hi,lo} right by off bytes, keeps the size field and zero/sign-extends it; ports hi, lo, off, size, uint in, res out
module load_format
  import load_align_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  hi,
  input  logic [XLEN-1:0]  lo,
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             uint,
  output logic [XLEN-1:0]  res
);
  logic [XLEN-1:0] w, mask;
  logic sign;
  always_comb begin
    w = XLEN'({hi, lo} >> {off, 3'b000});
    mask = XLEN'(size_mask(size));
    sign = size == LS_BYTE ? w[7] : size == LS_HALF ? w[15] : size == LS_WORD ? w[31] : w[XLEN-1];
    res = (w & mask) | (~mask & {XLEN{sign & ~uint}});
  end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: load request -> one or two RAM reads -> formatted, held response; ports clk/rst/flush, req_* handshake in, mem_rd_* RAM port, rsp_* handshake out
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW = 32,
  parameter int TAG_W = 5,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AW-1:0]             req_addr,
  input  logic [1:0]                req_size,
  input  logic                      req_uint,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      mem_rd_en,
  output logic [AW-$clog2(XLEN/8)-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]           mem_rd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [XLEN-1:0]           rsp_data,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic                      rsp_err
);
  localparam int NB = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IW = AW - OFF_W;
  lau_state_e state;
  logic [IW-1:0] idx_r;
  logic [OFF_W-1:0] off_r;
  logic [1:0] size_r;
  logic uint_r, cross_r;
  logic [XLEN-1:0] lo_r, fmt, fmt_hi, fmt_lo;
  logic [4:0] end_in;
  logic accept, cross_in, illegal_in;
  assign end_in = 5'(req_addr[OFF_W-1:0]) + (5'd1 << req_size);
  assign cross_in = end_in > 5'(NB);
  assign illegal_in = (req_size == LS_DWORD && XLEN == 32) || (cross_in && ALLOW_MISALIGN == 0);
  assign req_ready = ~rst & ~flush & (state == LAU_IDLE);
  assign accept = req_valid & req_ready;
  // the second read of a boundary-crossing load wraps around the top of the index space
  assign mem_rd_en = (accept & ~illegal_in) | (~rst & ~flush & (state == LAU_RD0) & cross_r);
  assign mem_rd_addr = state == LAU_IDLE ? req_addr[AW-1:OFF_W] : idx_r + IW'(1);
  assign rsp_valid = state == LAU_RESP;
  // RD0 formats straight from the RAM word; RD1 pairs the new word (hi) with the captured lo
  assign fmt_hi = state == LAU_RD1 ? mem_rd_data : '0;
  assign fmt_lo = state == LAU_RD1 ? lo_r : mem_rd_data;
  load_format #(.XLEN(XLEN), .OFF_W(OFF_W)) u_fmt (
    .hi(fmt_hi),
    .lo(fmt_lo),
    .off(off_r),
    .size(size_r),
    .uint(uint_r),
    .res(fmt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LAU_IDLE;
      idx_r <= '0;
      off_r <= '0;
      size_r <= '0;
      uint_r <= 1'b0;
      cross_r <= 1'b0;
      lo_r <= '0;
      rsp_data <= '0;
      rsp_tag <= '0;
      rsp_err <= 1'b0;
    end else if (flush) begin
      state <= LAU_IDLE;
    end else begin
      case (state)
        LAU_IDLE: if (accept) begin
          idx_r <= req_addr[AW-1:OFF_W];
          off_r <= req_addr[OFF_W-1:0];
          size_r <= req_size;
          uint_r <= req_uint;
          cross_r <= cross_in;
          rsp_tag <= req_tag;
          rsp_err <= illegal_in;
          rsp_data <= '0;
          state <= illegal_in ? LAU_RESP : LAU_RD0;
        end
        LAU_RD0: begin
          lo_r <= mem_rd_data;
          if (!cross_r) rsp_data <= fmt;
          state <= cross_r ? LAU_RD1 : LAU_RESP;
        end
        LAU_RD1: begin
          rsp_data <= fmt;
          state <= LAU_RESP;
        end
        default: if (rsp_ready) state <= LAU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: table-driven scoreboard bench over 32-bit, 32-bit strict-alignment and 64-bit instances
module tb_load_align_unit;
  typedef struct packed {
    int d;
    logic [31:0] addr;
    logic [1:0] size;
    logic uint;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] exp;
    logic err;
    int lat;
    int nr;
  } vec_t;
  typedef struct packed {
    logic [63:0] data;
    logic [4:0] tag;
    logic err;
  } rsp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, rrdy = 1'b0;
  logic rv [3];
  logic [31:0] addr = '0;
  logic [1:0] size = '0;
  logic uint = 1'b0;
  logic [4:0] tag = '0;
  logic rdy [3], en [3], vld [3], err [3];
  logic [4:0] rtag [3];
  logic [29:0] ra0, ra1;
  logic [28:0] ra2;
  logic [31:0] data0, data1, md0, md1;
  logic [63:0] data2, md2;
  logic [31:0] m32 [int];
  logic [63:0] m64 [int];
  logic [31:0] rdq [3][$];
  rsp_t sb [$];
  vec_t tbl [$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_addr(addr), .req_size(size), .req_uint(uint), .req_tag(tag),
    .mem_rd_en(en[0]), .mem_rd_addr(ra0), .mem_rd_data(md0),
    .rsp_valid(vld[0]), .rsp_ready(rrdy), .rsp_data(data0), .rsp_tag(rtag[0]), .rsp_err(err[0])
  );
  load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_addr(addr), .req_size(size), .req_uint(uint), .req_tag(tag),
    .mem_rd_en(en[1]), .mem_rd_addr(ra1), .mem_rd_data(md1),
    .rsp_valid(vld[1]), .rsp_ready(rrdy), .rsp_data(data1), .rsp_tag(rtag[1]), .rsp_err(err[1])
  );
  load_align_unit #(.XLEN(64), .ALLOW_MISALIGN(1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_addr(addr), .req_size(size), .req_uint(uint), .req_tag(tag),
    .mem_rd_en(en[2]), .mem_rd_addr(ra2), .mem_rd_data(md2),
    .rsp_valid(vld[2]), .rsp_ready(rrdy), .rsp_data(data2), .rsp_tag(rtag[2]), .rsp_err(err[2])
  );
  function automatic logic [31:0] rd32(input int a);
    return m32.exists(a) ? m32[a] : 32'h0;
  endfunction
  function automatic logic [63:0] rd64(input int a);
    return m64.exists(a) ? m64[a] : 64'h0;
  endfunction
  always @(posedge clk) begin
    if (en[0]) md0 <= rd32(int'(ra0));
    if (en[1]) md1 <= rd32(int'(ra1));
    if (en[2]) md2 <= rd64(int'(ra2));
    if (!rst) begin
      if (en[0]) rdq[0].push_back(32'(ra0));
      if (en[1]) rdq[1].push_back(32'(ra1));
      if (en[2]) rdq[2].push_back(32'(ra2));
    end
  end
  function automatic logic [63:0] dat(input int d);
    return d == 0 ? {32'h0, data0} : d == 1 ? {32'h0, data1} : data2;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input vec_t v, input logic [4:0] t);
    int lat, i0, i1;
    rsp_t e;
    i0 = v.d == 2 ? int'(v.addr >> 3) : int'(v.addr >> 2);
    i1 = v.d == 2 ? ((i0 + 1) & 32'h1FFF_FFFF) : ((i0 + 1) & 32'h3FFF_FFFF);
    if (v.d == 2) begin
      m64[i0] = v.w0;
      m64[i1] = v.w1;
    end else begin
      m32[i0] = v.w0[31:0];
      m32[i1] = v.w1[31:0];
    end
    rdq[v.d].delete();
    @(posedge clk); #1;
    chk("req_ready_idle", 64'(rdy[v.d]), 64'd1);
    rv[v.d] = 1'b1; addr = v.addr; size = v.size; uint = v.uint; tag = t;
    sb.push_back('{v.exp, t, v.err});
    @(posedge clk); #1;
    rv[v.d] = 1'b0;
    lat = 1;
    while (!vld[v.d] && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    e = sb.pop_front();
    chk("rsp_data", dat(v.d), e.data);
    chk("rsp_tag", 64'(rtag[v.d]), 64'(e.tag));
    chk("rsp_err", 64'(err[v.d]), 64'(e.err));
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    chk("rsp_valid_drop", 64'(vld[v.d]), 64'd0);
    chk("read_count", 64'(rdq[v.d].size()), 64'(v.nr));
    if (v.nr > 0) chk("read_idx0", 64'(rdq[v.d][0]), 64'(i0));
    if (v.nr > 1) chk("read_idx1", 64'(rdq[v.d][1]), 64'(i1));
  endtask
  initial begin
    int lat;
    rsp_t e;
    for (int k = 0; k < 3; k++) rv[k] = 1'b0;
    tbl.push_back('{0, 32'h100, 2'd2, 1'b0, 64'h8899AABB, 64'h0, 64'h8899AABB, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h103, 2'd0, 1'b0, 64'h80112233, 64'h0, 64'hFFFFFF80, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h103, 2'd0, 1'b1, 64'h80112233, 64'h0, 64'h00000080, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h101, 2'd1, 1'b0, 64'h80112233, 64'h0, 64'h00001122, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h102, 2'd1, 1'b0, 64'h80112233, 64'h0, 64'hFFFF8011, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h102, 2'd0, 1'b0, 64'h80112233, 64'h0, 64'h00000011, 1'b0, 2, 1});
    tbl.push_back('{0, 32'h103, 2'd1, 1'b0, 64'hAB000000, 64'hCD, 64'hFFFFCDAB, 1'b0, 3, 2});
    tbl.push_back('{0, 32'h103, 2'd1, 1'b1, 64'hAB000000, 64'hCD, 64'h0000CDAB, 1'b0, 3, 2});
    tbl.push_back('{0, 32'h101, 2'd2, 1'b0, 64'h80112233, 64'h445566CC, 64'hCC801122, 1'b0, 3, 2});
    tbl.push_back('{0, 32'hFFFFFFFF, 2'd1, 1'b1, 64'h7F000000, 64'h12, 64'h0000127F, 1'b0, 3, 2});
    tbl.push_back('{0, 32'h100, 2'd3, 1'b0, 64'h80112233, 64'h0, 64'h0, 1'b1, 1, 0});
    tbl.push_back('{1, 32'h102, 2'd2, 1'b0, 64'h80112233, 64'h0, 64'h0, 1'b1, 1, 0});
    tbl.push_back('{1, 32'h100, 2'd2, 1'b0, 64'h80112233, 64'h0, 64'h80112233, 1'b0, 2, 1});
    tbl.push_back('{1, 32'h103, 2'd0, 1'b0, 64'h80112233, 64'h0, 64'hFFFFFF80, 1'b0, 2, 1});
    tbl.push_back('{2, 32'h3FC, 2'd3, 1'b0, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 64'hDDEEFF0011223344, 1'b0, 3, 2});
    tbl.push_back('{2, 32'h3FC, 2'd3, 1'b1, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 64'hDDEEFF0011223344, 1'b0, 3, 2});
    tbl.push_back('{2, 32'h404, 2'd2, 1'b0, 64'h99AABBCCDDEEFF00, 64'h0, 64'hFFFFFFFF99AABBCC, 1'b0, 2, 1});
    tbl.push_back('{2, 32'h404, 2'd2, 1'b1, 64'h99AABBCCDDEEFF00, 64'h0, 64'h0000000099AABBCC, 1'b0, 2, 1});
    tbl.push_back('{2, 32'h3F8, 2'd3, 1'b0, 64'h8000000000000001, 64'h0, 64'h8000000000000001, 1'b0, 2, 1});
    tbl.push_back('{2, 32'h3FF, 2'd1, 1'b0, 64'h1122334455667788, 64'h99AABBCCDDEEFF80, 64'hFFFFFFFFFFFF8011, 1'b0, 3, 2});
    // reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rsp_valid", 64'(vld[k]), 64'd0);
      chk("rst_mem_rd_en", 64'(en[k]), 64'd0);
      chk("rst_rsp_tag", 64'(rtag[k]), 64'd0);
      chk("rst_rsp_err", 64'(err[k]), 64'd0);
      chk("rst_rsp_data", dat(k), 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", 64'(rdy[0]), 64'd1);
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], 5'(i + 1));
    // backpressure: response held, second request waits until after the handshake
    m32[32'h40] = 32'h8899AABB;
    m32[32'h50] = 32'h000000A5;
    @(posedge clk); #1;
    rv[0] = 1'b1; addr = 32'h100; size = 2'd2; uint = 1'b0; tag = 5'd3;
    sb.push_back('{64'h8899AABB, 5'd3, 1'b0});
    @(posedge clk); #1;
    rv[0] = 1'b0;
    lat = 1;
    while (!vld[0] && lat < 8) begin @(posedge clk); #1; lat++; end
    addr = 32'h140; size = 2'd0; uint = 1'b1; tag = 5'd9; rv[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_rsp_valid", 64'(vld[0]), 64'd1);
      chk("bp_rsp_data", dat(0), 64'h8899AABB);
      chk("bp_req_ready", 64'(rdy[0]), 64'd0);
      chk("bp_no_read", 64'(en[0]), 64'd0);
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk("bp_data", dat(0), e.data);
    chk("bp_tag", 64'(rtag[0]), 64'(e.tag));
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    chk("bp_valid_drop", 64'(vld[0]), 64'd0);
    chk("bp_req_ready_after", 64'(rdy[0]), 64'd1);
    chk("bp_2nd_read", 64'(en[0]), 64'd1);
    chk("bp_2nd_idx", 64'(ra0), 64'h50);
    sb.push_back('{64'hA5, 5'd9, 1'b0});
    @(posedge clk); #1;
    rv[0] = 1'b0;
    lat = 1;
    while (!vld[0] && lat < 8) begin @(posedge clk); #1; lat++; end
    chk("bp_2nd_latency", 64'(lat), 64'd2);
    e = sb.pop_front();
    chk("bp_2nd_data", dat(0), e.data);
    chk("bp_2nd_tag", 64'(rtag[0]), 64'(e.tag));
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    // flush during RD1 of a crossing load
    m32[32'h40] = 32'hAB000000;
    m32[32'h41] = 32'h000000CD;
    @(posedge clk); #1;
    rv[0] = 1'b1; addr = 32'h103; size = 2'd1; uint = 1'b0; tag = 5'd7;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("rd0_cross_read", 64'(en[0]), 64'd1);
    chk("rd0_cross_idx", 64'(ra0), 64'h41);
    @(posedge clk); #1;
    chk("rd1_no_read", 64'(en[0]), 64'd0);
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 64'(rdy[0]), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("flush_no_rsp", 64'(vld[0]), 64'd0);
      @(posedge clk); #1;
    end
    run(tbl[6], 5'd11);
    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    rv[0] = 1'b1; addr = 32'h100; size = 2'd2; uint = 1'b0; tag = 5'd4; flush = 1'b1;
    #1;
    chk("idle_flush_ready", 64'(rdy[0]), 64'd0);
    chk("idle_flush_no_read", 64'(en[0]), 64'd0);
    @(posedge clk); #1;
    rv[0] = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("idle_flush_no_rsp", 64'(vld[0]), 64'd0);
      @(posedge clk); #1;
    end
    // asynchronous reset in the middle of RD0
    @(posedge clk); #1;
    rv[0] = 1'b1; addr = 32'h103; size = 2'd1; uint = 1'b0; tag = 5'h1F;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(vld[0]), 64'd0);
    chk("arst_mem_rd_en", 64'(en[0]), 64'd0);
    chk("arst_req_ready", 64'(rdy[0]), 64'd0);
    chk("arst_rsp_tag", 64'(rtag[0]), 64'd0);
    chk("arst_rsp_data", dat(0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("arst_no_rsp", 64'(vld[0]), 64'd0);
      @(posedge clk); #1;
    end
    run(tbl[0], 5'd12);
    run(tbl[14], 5'd13);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
